// File: rtl/wb_slv_router.sv
// wb_slv_router: single-outstanding Wishbone router from one master to four address-decoded slaves
module wb_slv_router #(
  parameter logic [7:0]  TOUT    = 8'd255,
  parameter logic [31:0] ERR_DAT = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         m_cyc_i,
  input  logic         m_stb_i,
  input  logic         m_we_i,
  input  logic [31:0]  m_adr_i,
  input  logic [3:0]   m_sel_i,
  input  logic [31:0]  m_dat_i,
  output logic [31:0]  m_dat_o,
  output logic         m_ack_o,
  output logic         m_err_o,
  output logic [3:0]   s_cyc_o,
  output logic [3:0]   s_stb_o,
  output logic         s_we_o,
  output logic [31:0]  s_adr_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_dat_o,
  input  logic [127:0] s_dat_i,
  input  logic [3:0]   s_ack_i,
  input  logic [3:0]   s_err_i
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic [1:0]  idx;
  logic [7:0]  cnt;
  logic        mapped, hit_ack, hit_err, done, resp_err, resp_ack;
  logic [1:0]  dec;
  logic [3:0]  onehot;
  logic [31:0] rd_dat;
  always_comb begin
    mapped   = m_adr_i[31:28] >= 4'h1 && m_adr_i[31:28] <= 4'h4;
    dec      = m_adr_i[29:28] - 2'd1;
    onehot   = mapped ? 4'b0001 << dec : 4'b0000;
    hit_ack  = s_ack_i[idx];
    hit_err  = s_err_i[idx];
    rd_dat   = s_dat_i[{idx, 5'd0} +: 32];
    done     = !m_cyc_i || hit_err || hit_ack || cnt == TOUT - 8'd1;
    resp_err = m_cyc_i && (hit_err || !hit_ack);
    resp_ack = m_cyc_i && !hit_err && hit_ack;
  end
  // A slave error outranks its ack, and either outranks the timeout; an abort outranks all
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
      s_cyc_o <= '0;
      s_stb_o <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_sel_o <= '0;
      s_dat_o <= '0;
    end else begin
      case (state)
        IDLE: if (m_cyc_i && m_stb_i) begin
          s_we_o  <= m_we_i;
          s_adr_o <= m_adr_i;
          s_sel_o <= m_sel_i;
          s_dat_o <= m_dat_i;
          idx     <= dec;
          cnt     <= '0;
          s_cyc_o <= onehot;
          s_stb_o <= onehot;
          m_err_o <= !mapped;
          if (!mapped) m_dat_o <= ERR_DAT;
          state   <= mapped ? BUSY : RESP;
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (done) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            m_err_o <= resp_err;
            m_ack_o <= resp_ack;
            if (resp_err) m_dat_o <= ERR_DAT;
            else if (resp_ack && !s_we_o) m_dat_o <= rd_dat;
            state   <= m_cyc_i ? RESP : IDLE;
          end
        end
        default: begin
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_slv_router.sv
// tb_wb_slv_router: randomized transactions against a transaction-timeline model, plus literal pins
module tb_wb_slv_router;
  localparam logic [7:0]  TO  = 8'd4;
  localparam int          TOI = 4;
  localparam logic [31:0] ED  = 32'hDEAD_BEEF;
  logic         clk = 1'b0, rstn = 1'b0;
  logic         m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, s_we_o;
  logic [31:0]  m_adr_i, m_dat_i, m_dat_o, s_adr_o, s_dat_o;
  logic [3:0]   m_sel_i, s_cyc_o, s_stb_o, s_sel_o, s_ack_i, s_err_i;
  logic [127:0] s_dat_i;
  wb_slv_router #(.TOUT(TO), .ERR_DAT(ED)) dut (
    .clk(clk), .rstn(rstn), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit chk = 1'b0;
  logic [3:0]  ex_stb = '0, sh_sel = '0;
  logic        ex_ack = 1'b0, ex_err = 1'b0, sh_we = 1'b0;
  logic [31:0] md = '0, sh_adr = '0, sh_dat = '0;
  int seg = 0, seg_seen = 0, pin_id = 0, pin_seen = 0;
  int n_stb = 0, n_rise = 0, n_ack = 0, n_err = 0;
  logic [3:0] last_stb = '0, prev_stb = '0, p_last = '0;
  int p_stb, p_rise, p_ack, p_err;
  logic [31:0] p_dat = '0;
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // Single compare process: pinned literals first, then per-cycle model comparison
  initial forever begin
    @(negedge clk);
    if (pin_id != pin_seen) begin
      pin_seen = pin_id;
      cmp("pin_nstb", n_stb, p_stb);
      cmp("pin_nrise", n_rise, p_rise);
      cmp("pin_nack", n_ack, p_ack);
      cmp("pin_nerr", n_err, p_err);
      cmp("pin_last_stb", 32'(last_stb), 32'(p_last));
      cmp("pin_m_dat", m_dat_o, p_dat);
    end
    if (seg != seg_seen) begin
      seg_seen = seg;
      n_stb = 0; n_rise = 0; n_ack = 0; n_err = 0; last_stb = '0;
    end
    if (s_stb_o != 4'b0) begin
      n_stb++;
      last_stb = s_stb_o;
      if (prev_stb == 4'b0) n_rise++;
    end
    prev_stb = s_stb_o;
    n_ack += int'(m_ack_o);
    n_err += int'(m_err_o);
    if (chk) begin
      cmp("s_cyc", 32'(s_cyc_o), 32'(ex_stb));
      cmp("s_stb", 32'(s_stb_o), 32'(ex_stb));
      cmp("m_ack", 32'(m_ack_o), 32'(ex_ack));
      cmp("m_err", 32'(m_err_o), 32'(ex_err));
      cmp("m_dat", m_dat_o, md);
      cmp("s_we", 32'(s_we_o), 32'(sh_we));
      cmp("s_adr", s_adr_o, sh_adr);
      cmp("s_sel", 32'(s_sel_o), 32'(sh_sel));
      cmp("s_dat", s_dat_o, sh_dat);
    end
  end
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      m_cyc_i = 1'($urandom_range(0, 1)); m_stb_i = 1'b0; m_adr_i = $urandom;
      s_ack_i = 4'($urandom); s_err_i = 4'($urandom);
      s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      ex_stb = '0; ex_ack = 1'b0; ex_err = 1'b0;
      @(posedge clk); #1;
    end
  endtask
  // Cycle 0 presents the request; the outcome lands at cycle e+1 where e = min(abort, response, TOUT)
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int d, input int kind, input int ab,
                         input bit hold, input logic [31:0] rd, input logic [3:0] fa);
    bit mp;
    int sl, e, rk;
    mp = adr[31:28] >= 4'h1 && adr[31:28] <= 4'h4;
    sl = mp ? int'(adr[31:28]) - 1 : 0;
    if (!mp) begin e = 0; rk = 1; end
    else if (ab > 0) begin e = ab; rk = 2; end
    else if (d <= TOI) begin e = d; rk = kind; end
    else begin e = TOI; rk = 1; end
    for (int t = 0; t <= e + 1; t++) begin
      if (t == 0) begin
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_sel_i = sel; m_dat_i = dat;
      end else begin
        m_cyc_i = (t <= e) ? !(rk == 2 && t == e) : (hold && rk != 2);
        m_stb_i = m_cyc_i; m_we_i = 1'($urandom_range(0, 1)); m_adr_i = $urandom;
        m_sel_i = 4'($urandom); m_dat_i = $urandom;
      end
      s_ack_i = fa != 4'b0 ? fa : 4'($urandom);
      s_err_i = fa != 4'b0 ? 4'b0 : 4'($urandom);
      s_dat_i = {$urandom, $urandom, $urandom, $urandom};
      if (mp && t >= 1 && t <= e) begin
        s_ack_i[sl] = 1'b0; s_err_i[sl] = 1'b0;
        if (t == d) begin
          s_dat_i[sl*32 +: 32] = rd;
          s_ack_i[sl] = 1'b1;
          if (kind != 0) s_err_i[sl] = 1'b1;
        end
      end
      ex_stb = (mp && t >= 1 && t <= e) ? 4'(1 << sl) : 4'b0;
      ex_ack = t == e + 1 && rk == 0;
      ex_err = t == e + 1 && rk == 1;
      if (t == 1) begin sh_we = we; sh_adr = adr; sh_sel = sel; sh_dat = dat; end
      if (t == e + 1) md = rk == 1 ? ED : (rk == 0 && !we) ? rd : md;
      @(posedge clk); #1;
    end
  endtask
  task automatic pin(input int s, input int r, input int a, input int er,
                     input logic [3:0] l, input logic [31:0] dv);
    p_stb = s; p_rise = r; p_ack = a; p_err = er; p_last = l; p_dat = dv;
    pin_id++;
    idle(1);
  endtask
  initial begin
    logic [3:0] top;
    int d, ab, lim;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0; m_adr_i = '0; m_sel_i = '0; m_dat_i = '0;
    s_ack_i = '0; s_err_i = '0; s_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk = 1'b1;
    idle(1);
    rstn = 1'b1;
    seg++; run_txn(32'h2000_0010, 1'b0, 4'hF, 32'h0, 2, 0, 0, 1'b0, 32'h1234_5678, 4'b0);
    pin(2, 1, 1, 0, 4'b0010, 32'h1234_5678);
    seg++; run_txn(32'h9000_0000, 1'b1, 4'hF, 32'hCAFE, 1, 0, 0, 1'b0, 32'h0, 4'b0);
    pin(0, 0, 0, 1, 4'b0000, 32'hDEAD_BEEF);
    seg++; run_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 99, 0, 0, 1'b0, 32'h0, 4'b0);
    pin(4, 1, 0, 1, 4'b1000, 32'hDEAD_BEEF);
    seg++; run_txn(32'h1000_0000, 1'b0, 4'hF, 32'h0, 1, 1, 0, 1'b0, 32'h1111, 4'b0011);
    pin(1, 1, 0, 1, 4'b0001, 32'hDEAD_BEEF);
    seg++; run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 99, 0, 2, 1'b0, 32'h0, 4'b0);
    pin(2, 1, 0, 0, 4'b0100, 32'hDEAD_BEEF);
    seg++; run_txn(32'h1000_0008, 1'b0, 4'h3, 32'h0, 1, 0, 0, 1'b0, 32'hA5A5_0001, 4'b0);
    pin(1, 1, 1, 0, 4'b0001, 32'hA5A5_0001);
    seg++;
    run_txn(32'h2000_0100, 1'b1, 4'hF, 32'h5555, 1, 0, 0, 1'b1, 32'h7777, 4'b0);
    run_txn(32'h3000_0200, 1'b0, 4'hF, 32'h0, 3, 0, 0, 1'b1, 32'hC0DE_0003, 4'b0);
    pin(4, 2, 2, 0, 4'b0100, 32'hC0DE_0003);
    // Reset asserted while slave2 is being strobed
    seg++;
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h3000_0040;
    m_sel_i = 4'hF; m_dat_i = 32'h0; s_ack_i = '0; s_err_i = '0;
    ex_stb = '0; ex_ack = 1'b0; ex_err = 1'b0;
    @(posedge clk); #1;
    sh_we = 1'b0; sh_adr = 32'h3000_0040; sh_sel = 4'hF; sh_dat = 32'h0; ex_stb = 4'b0100;
    @(posedge clk); #1;
    rstn = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    ex_stb = '0; md = '0; sh_we = 1'b0; sh_adr = '0; sh_sel = '0; sh_dat = '0;
    pin(1, 1, 0, 0, 4'b0100, 32'h0);
    rstn = 1'b1;
    seg++; run_txn(32'h1000_0004, 1'b0, 4'hF, 32'h0, 1, 0, 0, 1'b0, 32'h0BAD_F00D, 4'b0);
    pin(1, 1, 1, 0, 4'b0001, 32'h0BAD_F00D);
    for (int i = 0; i < 300; i++) begin
      top = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'($urandom_range(1, 4));
      d   = $urandom_range(1, TOI + 2);
      lim = d < TOI ? d : TOI;
      ab  = 0;
      if (top >= 4'h1 && top <= 4'h4 && lim >= 2 && $urandom_range(0, 5) == 0)
        ab = $urandom_range(1, lim - 1);
      idle($urandom_range(0, 2));
      run_txn({top, 28'($urandom)}, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, d,
              $urandom_range(0, 1), ab, 1'($urandom_range(0, 1)), $urandom, 4'b0);
    end
    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
